// File: rtl/usb_pkg.sv
// Shared USB receive-side definitions: PID decoder state encoding, SYNC byte
// and the token/data/handshake PID values.
package usb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SYNC_OK  = 2'd1,
        ST_BODY     = 2'd2,
        ST_ERR_WAIT = 2'd3
    } pid_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

endpackage

// File: rtl/pid_decoder.sv
// Extracts the PID byte that follows SYNC in each received USB packet and
// pushes it into the downstream PID FIFO; malformed headers raise pid_error.
//
// state       | meaning
// ST_IDLE     | between packets, waiting for SYNC
// ST_SYNC_OK  | SYNC seen, next byte is the PID
// ST_BODY     | PID handled, payload bytes ignored until eop
// ST_ERR_WAIT | header bad or line error, ignoring bytes until eop
module pid_decoder
    import usb_pkg::*;
#(
    parameter int CHECK_PID = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       byte_valid,
    input  logic       eop,
    input  logic       rx_error,
    input  logic       fifo_full,
    output logic       pid_w_enable,
    output logic [7:0] pid_w_data,
    output logic       pid_error,
    output logic       overflow,
    output logic [7:0] drop_count,
    output logic       pkt_active
);

    pid_state_t r_state;
    pid_state_t w_state_next;

    logic       r_pid_w_enable;
    logic [7:0] r_pid_w_data;
    logic       r_pid_error;
    logic       r_overflow;
    logic [7:0] r_drop_count;
    logic       r_pkt_active;

    logic w_pid_ok;
    logic w_wr;
    logic w_drop;
    logic w_err;

    // The upper nibble of a PID carries the ones-complement of the lower one.
    assign w_pid_ok = (CHECK_PID == 0) || (rx_byte[7:4] == ~rx_byte[3:0]);

    always_comb begin
        w_state_next = r_state;
        w_wr         = 1'b0;
        w_drop       = 1'b0;
        w_err        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (byte_valid) begin
                    if (rx_byte == SYNC_BYTE) begin
                        w_state_next = ST_SYNC_OK;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = ST_ERR_WAIT;
                    end
                end
            end
            ST_SYNC_OK: begin
                if (rx_error) begin
                    w_state_next = ST_ERR_WAIT;
                end else if (byte_valid) begin
                    if (!w_pid_ok) begin
                        w_err        = 1'b1;
                        w_state_next = ST_ERR_WAIT;
                    end else begin
                        w_wr         = !fifo_full;
                        w_drop       = fifo_full;
                        w_state_next = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (rx_error) begin
                    w_state_next = ST_ERR_WAIT;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase

        // eop acts on the state reached after this cycle's byte; ending while
        // still expecting a PID means the packet had no PID at all.
        if (eop) begin
            if (w_state_next == ST_SYNC_OK) begin
                w_err = 1'b1;
            end
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_pid_w_enable <= 1'b0;
            r_pid_w_data   <= 8'h00;
            r_pid_error    <= 1'b0;
            r_overflow     <= 1'b0;
            r_drop_count   <= 8'h00;
            r_pkt_active   <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pid_w_enable <= w_wr;
            r_pid_error    <= w_err;
            r_pkt_active   <= (w_state_next != ST_IDLE);
            if (w_wr) begin
                r_pid_w_data <= rx_byte;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    assign pid_w_enable = r_pid_w_enable;
    assign pid_w_data   = r_pid_w_data;
    assign pid_error    = r_pid_error;
    assign overflow     = r_overflow;
    assign drop_count   = r_drop_count;
    assign pkt_active   = r_pkt_active;

endmodule

// File: tb/tb_pid_decoder.sv
// Bench for pid_decoder: a checked instance (CHECK_PID=1) and an unchecked one
// (CHECK_PID=0) share stimulus; expected FIFO writes are queued per instance.
module tb_pid_decoder;
    import usb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       byte_valid = 1'b0;
    logic       eop = 1'b0;
    logic       rx_error = 1'b0;
    logic       fifo_full = 1'b0;

    logic       a_wen, a_perr, a_ovf, a_act;
    logic [7:0] a_wdata, a_cnt;
    logic       b_wen, b_perr, b_ovf, b_act;
    logic [7:0] b_wdata, b_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    pid_decoder #(.CHECK_PID(1)) u_dut_a (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .byte_valid(byte_valid),
        .eop(eop), .rx_error(rx_error), .fifo_full(fifo_full),
        .pid_w_enable(a_wen), .pid_w_data(a_wdata), .pid_error(a_perr),
        .overflow(a_ovf), .drop_count(a_cnt), .pkt_active(a_act)
    );

    pid_decoder #(.CHECK_PID(0)) u_dut_b (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .byte_valid(byte_valid),
        .eop(eop), .rx_error(rx_error), .fifo_full(fifo_full),
        .pid_w_enable(b_wen), .pid_w_data(b_wdata), .pid_error(b_perr),
        .overflow(b_ovf), .drop_count(b_cnt), .pkt_active(b_act)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic bv, input logic e, input logic er);
        rx_byte    = b;
        byte_valid = bv;
        eop        = e;
        rx_error   = er;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        eop        = 1'b0;
        rx_error   = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        send(b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic put_eop();
        send(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic put_idle();
        send(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard side: every FIFO write must match the oldest expected PID.
    always @(negedge clk) begin
        if (!rst && a_wen === 1'b1) begin
            if (qa.size() == 0) chk("a_wr_unexpected", {24'h0, a_wdata}, 32'hFFFF_FFFF);
            else chk("a_wr_data", {24'h0, a_wdata}, {24'h0, qa.pop_front()});
        end
        if (!rst && b_wen === 1'b1) begin
            if (qb.size() == 0) chk("b_wr_unexpected", {24'h0, b_wdata}, 32'hFFFF_FFFF);
            else chk("b_wr_data", {24'h0, b_wdata}, {24'h0, qb.pop_front()});
        end
    end

    initial begin
        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen", a_wen, 0);
        chk("rst_wdata", a_wdata, 0);
        chk("rst_perr", a_perr, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_act", a_act, 0);
        rst = 1'b0;
        put_idle();

        // eop while idle is ignored
        put_eop();
        chk("idle_eop_perr", a_perr, 0);
        chk("idle_eop_act", a_act, 0);

        // good OUT packet
        put_byte(SYNC_BYTE);
        chk("out_act_sync", a_act, 1);
        chk("out_no_early_wr", a_wen, 0);
        qa.push_back(PID_OUT);
        qb.push_back(PID_OUT);
        put_byte(PID_OUT);
        chk("out_wen_lat1", a_wen, 1);
        chk("out_wdata", a_wdata, PID_OUT);
        put_byte(8'h12);
        chk("out_single_pulse", a_wen, 0);
        put_eop();
        chk("out_act_end", a_act, 0);
        put_idle();
        chk("hold_wdata", a_wdata, PID_OUT);

        // bad check nibble: error on A, written on B
        put_byte(SYNC_BYTE);
        qb.push_back(8'hE2);
        put_byte(8'hE2);
        chk("bad_perr_a", a_perr, 1);
        chk("bad_wen_a", a_wen, 0);
        chk("bad_wen_b", b_wen, 1);
        chk("bad_perr_b", b_perr, 0);
        put_idle();
        chk("bad_perr_pulse", a_perr, 0);
        chk("bad_errwait_act", a_act, 1);
        put_byte(SYNC_BYTE);
        put_byte(PID_DATA0);
        chk("errwait_ignore_wr", a_wen, 0);
        put_eop();
        chk("bad_act_end", a_act, 0);

        // FIFO full: drop and count
        fifo_full = 1'b1;
        put_byte(SYNC_BYTE);
        put_byte(PID_DATA0);
        chk("full_no_wr", a_wen, 0);
        chk("full_ovf", a_ovf, 1);
        chk("full_cnt1", a_cnt, 1);
        put_eop();
        for (int i = 1; i < 255; i++) begin
            put_byte(SYNC_BYTE);
            put_byte(PID_DATA0);
            put_eop();
        end
        chk("full_cnt255", a_cnt, 255);
        put_byte(SYNC_BYTE);
        put_byte(PID_DATA0);
        put_eop();
        chk("full_cnt_sat_a", a_cnt, 255);
        chk("full_cnt_sat_b", b_cnt, 255);
        fifo_full = 1'b0;

        // line error on the PID byte
        put_byte(SYNC_BYTE);
        send(PID_IN, 1'b1, 1'b0, 1'b1);
        chk("rxerr_no_wr", a_wen, 0);
        chk("rxerr_no_perr", a_perr, 0);
        chk("rxerr_act", a_act, 1);
        put_byte(SYNC_BYTE);
        put_byte(PID_IN);
        chk("rxerr_ignore", a_wen, 0);
        put_eop();
        chk("rxerr_act_end", a_act, 0);
        chk("ovf_sticky", a_ovf, 1);

        // PID and eop together, then a PID-less packet
        put_byte(SYNC_BYTE);
        qa.push_back(PID_ACK);
        qb.push_back(PID_ACK);
        send(PID_ACK, 1'b1, 1'b1, 1'b0);
        chk("ack_eop_wen", a_wen, 1);
        chk("ack_eop_idle", a_act, 0);
        put_byte(SYNC_BYTE);
        put_eop();
        chk("nopid_perr", a_perr, 1);
        chk("nopid_act", a_act, 0);
        chk("nopid_no_wr", a_wen, 0);

        // reset mid-packet
        put_byte(SYNC_BYTE);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_act", a_act, 0);
        chk("mid_rst_ovf", a_ovf, 0);
        chk("mid_rst_cnt", a_cnt, 0);
        chk("mid_rst_wdata", a_wdata, 0);
        rst = 1'b0;
        put_byte(PID_DATA1);
        chk("post_rst_perr_a", a_perr, 1);
        chk("post_rst_perr_b", b_perr, 1);
        chk("post_rst_no_wr", a_wen, 0);
        put_eop();
        chk("post_rst_act", a_act, 0);
        put_idle();

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
